// File: rtl/list_engine_pkg.sv
// Shared op codes, FSM encodings and helpers for the list_engine list store.
package list_engine_pkg;

   localparam logic [2:0] OP_READ       = 3'd0;
   localparam logic [2:0] OP_INSERT     = 3'd1;
   localparam logic [2:0] OP_DELETE     = 3'd2;
   localparam logic [2:0] OP_UPDATE     = 3'd3;
   localparam logic [2:0] OP_FIND_FIRST = 3'd4;
   localparam logic [2:0] OP_COUNT      = 3'd5;
   localparam logic [2:0] OP_MIN        = 3'd6;
   localparam logic [2:0] OP_MAX        = 3'd7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [0:0] {
      EXT_MIN = 1'b0,
      EXT_MAX = 1'b1
   } ext_mode_e;

   // Ops 4..7 walk the list chunk by chunk; 0..3 finish in one cycle.
   function automatic logic is_scan_op(input logic [2:0] op);
      return op >= OP_FIND_FIRST;
   endfunction

endpackage

// File: rtl/list_engine_scan_lane.sv
// One scan chunk: compares LANES entries against a key and finds the chunk extreme.
module list_scan_lane
   import list_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 2,
   parameter int SIGNED     = 0,
   localparam int OFF_W     = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int LCNT_W    = $clog2(LANES + 1)
) (
   input  logic [LANES*DATA_WIDTH-1:0] lane_data,
   input  logic [LANES-1:0]            lane_valid,
   input  logic [DATA_WIDTH-1:0]       key,
   input  ext_mode_e                   mode,
   output logic                        hit,
   output logic [OFF_W-1:0]            hit_off,
   output logic [LCNT_W-1:0]           match_cnt,
   output logic                        ext_valid,
   output logic [DATA_WIDTH-1:0]       ext_val,
   output logic [OFF_W-1:0]            ext_off
);

   logic [DATA_WIDTH-1:0] cur;

   function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input ext_mode_e             m);
      logic lt;
      logic gt;
      if (SIGNED != 0) begin
         lt = $signed(a) < $signed(b);
         gt = $signed(a) > $signed(b);
      end else begin
         lt = a < b;
         gt = a > b;
      end
      return (m == EXT_MAX) ? gt : lt;
   endfunction

   // Strict comparison keeps the lowest offset on ties.
   always_comb begin
      hit       = 1'b0;
      hit_off   = '0;
      match_cnt = '0;
      ext_valid = 1'b0;
      ext_val   = '0;
      ext_off   = '0;
      cur       = '0;
      for (int l = 0; l < LANES; l++) begin
         cur = lane_data[l*DATA_WIDTH +: DATA_WIDTH];
         if (lane_valid[l]) begin
            if (cur == key) begin
               if (!hit) begin
                  hit     = 1'b1;
                  hit_off = OFF_W'(l);
               end
               match_cnt = match_cnt + LCNT_W'(1);
            end
            if (!ext_valid || better(cur, ext_val, mode)) begin
               ext_valid = 1'b1;
               ext_val   = cur;
               ext_off   = OFF_W'(l);
            end
         end
      end
   end

endmodule

// File: rtl/list_engine.sv
// Packed list store with indexed edits and multi-lane scans behind valid/ready channels.
//   state | meaning
//   IDLE  | waiting for a request or clear; single-cycle ops commit here
//   SCAN  | walking chunks of LANES entries, accumulating count/extreme
//   RESP  | response held until rsp_ready
module list_engine
   import list_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int LANES      = 2,
   parameter int SIGNED     = 0,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [IDX_W-1:0]      req_index,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [IDX_W-1:0]      rsp_index,
   output logic                  rsp_error,
   output logic [CNT_W-1:0]      len,
   output logic                  full,
   output logic                  empty
);

   localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int LCNT_W = $clog2(LANES + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0]      len_q, len_d;
   logic                  full_q, empty_q;
   logic [1:0]            state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] key_q, key_d;
   logic [CNT_W-1:0]      base_q, base_d;
   logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
   logic                  acc_valid_q, acc_valid_d;
   logic [DATA_WIDTH-1:0] acc_ext_q, acc_ext_d;
   logic [IDX_W-1:0]      acc_idx_q, acc_idx_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [IDX_W-1:0]      rsp_index_q, rsp_index_d;
   logic                  rsp_error_q, rsp_error_d;

   logic [LANES*DATA_WIDTH-1:0] lane_data;
   logic [LANES-1:0]            lane_valid;
   logic [CNT_W-1:0]            lane_pos;
   ext_mode_e                   mode;
   logic                        hit;
   logic [OFF_W-1:0]            hit_off;
   logic [LCNT_W-1:0]           match_cnt;
   logic                        ext_valid;
   logic [DATA_WIDTH-1:0]       ext_val;
   logic [OFF_W-1:0]            ext_off;

   logic [CNT_W-1:0]      req_idx_ext;
   logic                  idx_in;
   logic [CNT_W-1:0]      ins_pos;
   logic                  last_chunk;
   logic [CNT_W-1:0]      hit_pos;
   logic [CNT_W-1:0]      ext_pos;
   logic [CNT_W-1:0]      cnt_sum;
   logic                  take_chunk;
   logic                  merged_valid;
   logic [DATA_WIDTH-1:0] merged_ext;
   logic [IDX_W-1:0]      merged_idx;

   function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input ext_mode_e             m);
      logic lt;
      logic gt;
      if (SIGNED != 0) begin
         lt = $signed(a) < $signed(b);
         gt = $signed(a) > $signed(b);
      end else begin
         lt = a < b;
         gt = a > b;
      end
      return (m == EXT_MAX) ? gt : lt;
   endfunction

   assign req_ready = (state_q == ST_IDLE) && !clear;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_index = rsp_index_q;
   assign rsp_error = rsp_error_q;
   assign len       = len_q;
   assign full      = full_q;
   assign empty     = empty_q;

   assign mode = (op_q == OP_MAX) ? EXT_MAX : EXT_MIN;

   always_comb begin
      lane_data  = '0;
      lane_valid = '0;
      lane_pos   = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_pos = base_q + CNT_W'(l);
         lane_data[l*DATA_WIDTH +: DATA_WIDTH] = mem_q[lane_pos[IDX_W-1:0]];
         lane_valid[l] = lane_pos < len_q;
      end
   end

   list_scan_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES),
      .SIGNED     (SIGNED)
   ) u_scan (
      .lane_data  (lane_data),
      .lane_valid (lane_valid),
      .key        (key_q),
      .mode       (mode),
      .hit        (hit),
      .hit_off    (hit_off),
      .match_cnt  (match_cnt),
      .ext_valid  (ext_valid),
      .ext_val    (ext_val),
      .ext_off    (ext_off)
   );

   always_comb begin
      req_idx_ext  = CNT_W'(req_index);
      idx_in       = req_idx_ext < len_q;
      ins_pos      = idx_in ? req_idx_ext : len_q;
      // The chunk is last once it reaches len; an empty list still spends one cycle.
      last_chunk   = ({1'b0, base_q} + (CNT_W+1)'(LANES)) >= {1'b0, len_q};
      hit_pos      = base_q + CNT_W'(hit_off);
      ext_pos      = base_q + CNT_W'(ext_off);
      cnt_sum      = acc_cnt_q + CNT_W'(match_cnt);
      take_chunk   = ext_valid && (!acc_valid_q || better(ext_val, acc_ext_q, mode));
      merged_valid = acc_valid_q || ext_valid;
      merged_ext   = take_chunk ? ext_val : acc_ext_q;
      merged_idx   = take_chunk ? ext_pos[IDX_W-1:0] : acc_idx_q;
   end

   always_comb begin
      mem_d       = mem_q;
      len_d       = len_q;
      state_d     = state_q;
      op_d        = op_q;
      key_d       = key_q;
      base_d      = base_q;
      acc_cnt_d   = acc_cnt_q;
      acc_valid_d = acc_valid_q;
      acc_ext_d   = acc_ext_q;
      acc_idx_d   = acc_idx_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_index_d = rsp_index_q;
      rsp_error_d = rsp_error_q;

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               len_d = '0;
               mem_d = '{default: '0};
            end else if (req_valid) begin
               op_d        = req_op;
               key_d       = req_data;
               base_d      = '0;
               acc_cnt_d   = '0;
               acc_valid_d = 1'b0;
               acc_ext_d   = '0;
               acc_idx_d   = '0;
               rsp_data_d  = '0;
               rsp_index_d = '0;
               rsp_error_d = 1'b0;
               if (is_scan_op(req_op)) begin
                  state_d = ST_SCAN;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  case (req_op)
                     OP_READ: begin
                        if (idx_in) begin
                           rsp_data_d  = mem_q[req_index];
                           rsp_index_d = req_index;
                        end else begin
                           rsp_error_d = 1'b1;
                        end
                     end
                     OP_INSERT: begin
                        if (len_q == CNT_W'(DEPTH)) begin
                           rsp_error_d = 1'b1;
                        end else begin
                           for (int i = 1; i < DEPTH; i++) begin
                              if (CNT_W'(i) > ins_pos && CNT_W'(i) <= len_q)
                                 mem_d[IDX_W'(i)] = mem_q[IDX_W'(i - 1)];
                           end
                           mem_d[ins_pos[IDX_W-1:0]] = req_data;
                           rsp_index_d = ins_pos[IDX_W-1:0];
                           len_d       = len_q + CNT_W'(1);
                        end
                     end
                     OP_DELETE: begin
                        if (idx_in) begin
                           rsp_data_d  = mem_q[req_index];
                           rsp_index_d = req_index;
                           for (int i = 0; i < DEPTH - 1; i++) begin
                              if (CNT_W'(i) >= req_idx_ext && CNT_W'(i) < len_q - CNT_W'(1))
                                 mem_d[IDX_W'(i)] = mem_q[IDX_W'(i + 1)];
                           end
                           mem_d[IDX_W'(len_q - CNT_W'(1))] = '0;
                           len_d = len_q - CNT_W'(1);
                        end else begin
                           rsp_error_d = 1'b1;
                        end
                     end
                     OP_UPDATE: begin
                        if (idx_in) begin
                           rsp_data_d       = mem_q[req_index];
                           rsp_index_d      = req_index;
                           mem_d[req_index] = req_data;
                        end else begin
                           rsp_error_d = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end

         ST_SCAN: begin
            base_d      = base_q + CNT_W'(LANES);
            acc_cnt_d   = cnt_sum;
            acc_valid_d = merged_valid;
            acc_ext_d   = merged_ext;
            acc_idx_d   = merged_idx;
            if (op_q == OP_FIND_FIRST && hit) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = key_q;
               rsp_index_d = hit_pos[IDX_W-1:0];
            end else if (last_chunk) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               case (op_q)
                  OP_COUNT: rsp_data_d = DATA_WIDTH'(cnt_sum);
                  OP_MIN, OP_MAX: begin
                     if (merged_valid) begin
                        rsp_data_d  = merged_ext;
                        rsp_index_d = merged_idx;
                     end else begin
                        rsp_error_d = 1'b1;
                     end
                  end
                  default: rsp_error_d = 1'b1;
               endcase
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q       <= '{default: '0};
         len_q       <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         state_q     <= ST_IDLE;
         op_q        <= OP_READ;
         key_q       <= '0;
         base_q      <= '0;
         acc_cnt_q   <= '0;
         acc_valid_q <= 1'b0;
         acc_ext_q   <= '0;
         acc_idx_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_index_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         len_q       <= len_d;
         full_q      <= (len_d == CNT_W'(DEPTH));
         empty_q     <= (len_d == '0);
         state_q     <= state_d;
         op_q        <= op_d;
         key_q       <= key_d;
         base_q      <= base_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_valid_q <= acc_valid_d;
         acc_ext_q   <= acc_ext_d;
         acc_idx_q   <= acc_idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_index_q <= rsp_index_d;
         rsp_error_q <= rsp_error_d;
      end
   end

endmodule

// File: tb/tb_list_engine.sv
// Directed bench for list_engine: an unsigned and a signed instance driven in lockstep.
module tb_list_engine;
   import list_engine_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       req_valid;
   logic       rsp_ready;
   logic [2:0] req_op;
   logic [2:0] req_index;
   logic [7:0] req_data;

   logic       req_ready, rsp_valid, rsp_error, full, empty;
   logic [7:0] rsp_data;
   logic [2:0] rsp_index;
   logic [3:0] len;

   logic       s_req_ready, s_rsp_valid, s_rsp_error, s_full, s_empty;
   logic [7:0] s_rsp_data;
   logic [2:0] s_rsp_index;
   logic [3:0] s_len;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] r_data, rs_data;
   logic [2:0] r_index, rs_index;
   logic       r_err, rs_err;
   int         r_lat;

   always #5 clk = ~clk;

   list_engine #(.DATA_WIDTH(8), .DEPTH(8), .LANES(2), .SIGNED(0)) dut (
      .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_index(req_index), .req_data(req_data), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_index(rsp_index), .rsp_error(rsp_error),
      .len(len), .full(full), .empty(empty)
   );

   list_engine #(.DATA_WIDTH(8), .DEPTH(8), .LANES(2), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(s_req_ready),
      .req_op(req_op), .req_index(req_index), .req_data(req_data), .rsp_valid(s_rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_index(s_rsp_index), .rsp_error(s_rsp_error),
      .len(s_len), .full(s_full), .empty(s_empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] idx, input logic [7:0] data);
      int guard;
      guard = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_index = idx;
      req_data  = data;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      r_lat = 1;
      while (!rsp_valid && r_lat < 40) begin
         @(posedge clk);
         #1;
         r_lat++;
      end
      if (!rsp_valid) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
      r_data   = rsp_data;
      r_index  = rsp_index;
      r_err    = rsp_error;
      rs_data  = s_rsp_data;
      rs_index = s_rsp_index;
      rs_err   = s_rsp_error;
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // exp_index < 0 skips the index check.
   task automatic run(input string tag, input logic [2:0] op, input logic [2:0] idx,
                      input logic [7:0] data, input int exp_data, input int exp_index,
                      input int exp_err, input int exp_lat);
      issue(op, idx, data);
      wait_rsp();
      chk({tag, "_data"}, 32'(r_data), 32'(exp_data));
      if (exp_index >= 0) chk({tag, "_index"}, 32'(r_index), 32'(exp_index));
      chk({tag, "_err"}, 32'(r_err), 32'(exp_err));
      chk({tag, "_lat"}, 32'(r_lat), 32'(exp_lat));
      ack();
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = OP_READ; req_index = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_len", 32'(len), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;

      run("ins5", OP_INSERT, 3'd0, 8'd5, 0, 0, 0, 1);
      run("ins3", OP_INSERT, 3'd0, 8'd3, 0, 0, 0, 1);
      run("ins9", OP_INSERT, 3'd7, 8'd9, 0, 2, 0, 1);
      chk("len3", 32'(len), 32'd3);
      chk("nonempty", 32'(empty), 32'd0);
      run("rd0", OP_READ, 3'd0, 8'd0, 3, 0, 0, 1);
      run("rd1", OP_READ, 3'd1, 8'd0, 5, 1, 0, 1);

      run("ff9", OP_FIND_FIRST, 3'd0, 8'd9, 9, 2, 0, 3);
      run("ff4", OP_FIND_FIRST, 3'd0, 8'd4, 0, 0, 1, 3);
      run("ff3", OP_FIND_FIRST, 3'd0, 8'd3, 3, 0, 0, 2);

      run("del1", OP_DELETE, 3'd1, 8'd0, 5, -1, 0, 1);
      chk("len_after_del", 32'(len), 32'd2);
      run("rd2_err", OP_READ, 3'd2, 8'd0, 0, 0, 1, 1);
      run("rd1_after_del", OP_READ, 3'd1, 8'd0, 9, 1, 0, 1);

      run("upd0", OP_UPDATE, 3'd0, 8'd5, 3, -1, 0, 1);
      run("upd1", OP_UPDATE, 3'd1, 8'd5, 9, -1, 0, 1);
      run("ins1", OP_INSERT, 3'd7, 8'd1, 0, 2, 0, 1);
      run("ins5b", OP_INSERT, 3'd7, 8'd5, 0, 3, 0, 1);
      run("cnt5", OP_COUNT, 3'd0, 8'd5, 3, -1, 0, 3);
      run("cnt7", OP_COUNT, 3'd0, 8'd7, 0, -1, 0, 3);
      run("max_5515", OP_MAX, 3'd0, 8'd0, 5, 0, 0, 3);
      run("min_5515", OP_MIN, 3'd0, 8'd0, 1, 2, 0, 3);

      run("ins_mid", OP_INSERT, 3'd1, 8'h20, 0, 1, 0, 1);
      run("rd2_shift", OP_READ, 3'd2, 8'd0, 5, 2, 0, 1);
      run("rd4_shift", OP_READ, 3'd4, 8'd0, 5, 4, 0, 1);
      run("ins6", OP_INSERT, 3'd7, 8'd6, 0, 5, 0, 1);
      run("ins7", OP_INSERT, 3'd7, 8'd7, 0, 6, 0, 1);
      run("ins8", OP_INSERT, 3'd7, 8'd8, 0, 7, 0, 1);
      chk("len8", 32'(len), 32'd8);
      chk("full8", 32'(full), 32'd1);
      run("ff8_last", OP_FIND_FIRST, 3'd0, 8'd8, 8, 7, 0, 5);
      run("ins_full", OP_INSERT, 3'd0, 8'd9, 0, 0, 1, 1);
      chk("len_full_err", 32'(len), 32'd8);
      chk("full_full_err", 32'(full), 32'd1);
      run("del0", OP_DELETE, 3'd0, 8'd0, 5, -1, 0, 1);
      chk("len7", 32'(len), 32'd7);
      chk("full7", 32'(full), 32'd0);
      run("rd6", OP_READ, 3'd6, 8'd0, 8, 6, 0, 1);
      run("rd7_err", OP_READ, 3'd7, 8'd0, 0, 0, 1, 1);

      @(negedge clk);
      clear = 1'b1; req_valid = 1'b1; req_op = OP_READ; req_index = 3'd0;
      #1;
      chk("clear_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0; req_valid = 1'b0;
      chk("clear_len", 32'(len), 32'd0);
      chk("clear_empty", 32'(empty), 32'd1);
      chk("clear_no_rsp", 32'(rsp_valid), 32'd0);

      run("min_empty", OP_MIN, 3'd0, 8'd0, 0, 0, 1, 2);
      run("cnt_empty", OP_COUNT, 3'd0, 8'd3, 0, -1, 0, 2);

      run("ins7f", OP_INSERT, 3'd7, 8'h7F, 0, 0, 0, 1);
      run("ins80", OP_INSERT, 3'd7, 8'h80, 0, 1, 0, 1);
      run("ins01", OP_INSERT, 3'd7, 8'h01, 0, 2, 0, 1);
      run("min_unsigned", OP_MIN, 3'd0, 8'd0, 8'h01, 2, 0, 3);
      chk("min_signed_data", 32'(rs_data), 32'h80);
      chk("min_signed_index", 32'(rs_index), 32'd1);
      chk("min_signed_err", 32'(rs_err), 32'd0);

      do_clear();
      run("ins4", OP_INSERT, 3'd7, 8'd4, 0, 0, 0, 1);
      run("ins7a", OP_INSERT, 3'd7, 8'd7, 0, 1, 0, 1);
      run("ins7b", OP_INSERT, 3'd7, 8'd7, 0, 2, 0, 1);
      run("max_477", OP_MAX, 3'd0, 8'd0, 7, 1, 0, 3);

      issue(OP_READ, 3'd1, 8'd0);
      wait_rsp();
      chk("hold_lat", 32'(r_lat), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_data", 32'(rsp_data), 32'd7);
         chk("hold_index", 32'(rsp_index), 32'd1);
         chk("hold_err", 32'(rsp_error), 32'd0);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      ack();
      chk("valid_drop", 32'(rsp_valid), 32'd0);

      issue(OP_COUNT, 3'd0, 8'd7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("scan_rst_valid", 32'(rsp_valid), 32'd0);
      chk("scan_rst_len", 32'(len), 32'd0);
      chk("scan_rst_empty", 32'(empty), 32'd1);
      chk("scan_rst_req_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      run("rd_after_rst", OP_READ, 3'd0, 8'd0, 0, 0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
